// File: rtl/gpr_pkg.sv
// Shared types and default sizes for the multi-port general-purpose register file.
package gpr_pkg;
  typedef enum logic {
    GPR_INIT = 1'b0,
    GPR_RUN  = 1'b1
  } gpr_state_e;

  localparam int GPR_DATA_W   = 32;
  localparam int GPR_NUM_REGS = 32;
  localparam int GPR_ZERO_IDX = 0;
endpackage

// File: rtl/gpr_read_port.sv
// One read mux: busy stall, hardwired zero register, then optional write bypass over array data.
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] num,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              arr_pending,
  input  logic              busy,
  input  logic              byp_hit,
  input  logic [DATA_W-1:0] byp_data,
  input  logic              byp_pending,
  output logic [DATA_W-1:0] data,
  output logic              pending
);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(GPR_ZERO_IDX);

  // Busy wins over the zero register so the whole pipe stalls during the clear sequence.
  always_comb begin
    data    = arr_data;
    pending = arr_pending;
    if (busy) begin
      data    = '0;
      pending = 1'b1;
    end else if (num == ZERO_IDX) begin
      data    = '0;
      pending = 1'b0;
    end else if (byp_hit) begin
      data    = byp_data;
      pending = byp_pending;
    end
  end
endmodule

// File: rtl/gpr_multiport.sv
// Parametrised register file with zero register, sequential clear, pending scoreboard and
// NUM_RD combinational read ports. Define GPR_BYPASS_EN to forward same-cycle writes to reads.
module gpr_multiport
  import gpr_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int NUM_REGS = GPR_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_num,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        num_write,
  input  logic [DATA_W-1:0]        data_write,
  input  logic                     alloc_valid,
  input  logic [ADDR_W-1:0]        alloc_num,
  output logic                     init_busy,
  output gpr_state_e               state_dbg
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(GPR_ZERO_IDX);

  gpr_state_e          state;
  gpr_state_e          state_next;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic                run;
  logic                wr_en;
  logic                al_en;

  always_ff @(posedge clock) begin
    if (reset) state <= GPR_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == GPR_INIT && clr_idx == LAST_IDX) state_next = GPR_RUN;
  end

  always_comb begin
    init_busy = (state == GPR_INIT);
    run       = (state == GPR_RUN);
    state_dbg = state;
  end

  assign wr_en = run && !reset && reg_write && (num_write != ZERO_IDX);
  assign al_en = run && !reset && alloc_valid && (alloc_num != ZERO_IDX);

  // Alloc is applied after the write clear so a same-index pair leaves the bit set.
  always_ff @(posedge clock) begin
    if (reset) begin
      clr_idx <= ADDR_W'(1);
      pending <= '0;
    end else if (init_busy) begin
      clr_idx <= clr_idx + 1'b1;
    end else begin
      if (wr_en) pending[num_write] <= 1'b0;
      if (al_en) pending[alloc_num] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && init_busy) regs[clr_idx]   <= '0;
    else if (wr_en)          regs[num_write] <= data_write;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] num;
    logic              hit;
    logic              hit_pend;

    assign num = rd_num[i*ADDR_W +: ADDR_W];
`ifdef GPR_BYPASS_EN
    assign hit      = wr_en && (num_write == num);
    assign hit_pend = al_en && (alloc_num == num);
`else
    assign hit      = 1'b0;
    assign hit_pend = 1'b0;
`endif

    gpr_read_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_port (
      .num        (num),
      .arr_data   (regs[num]),
      .arr_pending(pending[num]),
      .busy       (init_busy),
      .byp_hit    (hit),
      .byp_data   (data_write),
      .byp_pending(hit_pend),
      .data       (rd_data[i*DATA_W +: DATA_W]),
      .pending    (rd_pending[i])
    );
  end
endmodule

// File: tb/tb_gpr_multiport.sv
// Randomized scoreboard bench for gpr_multiport: default build plus a 16-bit/8-reg/3-port instance.
module tb_gpr_multiport;
  import gpr_pkg::*;

  localparam int DW = 32, NR = 32, AW = 5, NRD = 2;
  localparam int DW_B = 16, NR_B = 8, AW_B = 3, NRD_B = 3;
`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                reset;
  logic [NRD*AW-1:0]   rd_num;
  logic [NRD*DW-1:0]   rd_data;
  logic [NRD-1:0]      rd_pending;
  logic                reg_write;
  logic [AW-1:0]       num_write;
  logic [DW-1:0]       data_write;
  logic                alloc_valid;
  logic [AW-1:0]       alloc_num;
  logic                init_busy;
  gpr_state_e          state_dbg;

  logic                reset_b;
  logic [NRD_B*AW_B-1:0] rd_num_b;
  logic [NRD_B*DW_B-1:0] rd_data_b;
  logic [NRD_B-1:0]    rd_pending_b;
  logic                reg_write_b;
  logic [AW_B-1:0]     num_write_b;
  logic [DW_B-1:0]     data_write_b;
  logic                alloc_valid_b;
  logic [AW_B-1:0]     alloc_num_b;
  logic                init_busy_b;
  gpr_state_e          state_dbg_b;

  gpr_multiport u_dut (
    .clock(clock), .reset(reset), .rd_num(rd_num), .rd_data(rd_data), .rd_pending(rd_pending),
    .reg_write(reg_write), .num_write(num_write), .data_write(data_write),
    .alloc_valid(alloc_valid), .alloc_num(alloc_num), .init_busy(init_busy), .state_dbg(state_dbg)
  );

  gpr_multiport #(.DATA_W(DW_B), .NUM_REGS(NR_B), .NUM_RD(NRD_B)) u_dut_b (
    .clock(clock), .reset(reset_b), .rd_num(rd_num_b), .rd_data(rd_data_b),
    .rd_pending(rd_pending_b), .reg_write(reg_write_b), .num_write(num_write_b),
    .data_write(data_write_b), .alloc_valid(alloc_valid_b), .alloc_num(alloc_num_b),
    .init_busy(init_busy_b), .state_dbg(state_dbg_b)
  );

  // kind: 0 A data, 1 A pending, 2 A busy, 3 B data, 4 B pending, 5 B busy
  typedef struct {
    int          kind;
    int          port;
    logic [31:0] value;
    string       name;
  } chk_t;

  chk_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: contents are conceptually discarded on reset; reads stall while init counts down.
  logic [DW-1:0]   m_regs  [NR];
  logic            m_pend  [NR];
  int              m_left  = 0;
  logic [DW_B-1:0] mb_regs [NR_B];
  logic            mb_pend [NR_B];
  int              mb_left = 0;

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c = exp_q.pop_front();
      case (c.kind)
        0:       act = 32'(rd_data[c.port*DW +: DW]);
        1:       act = 32'(rd_pending[c.port]);
        2:       act = 32'(init_busy);
        3:       act = 32'(rd_data_b[c.port*DW_B +: DW_B]);
        4:       act = 32'(rd_pending_b[c.port]);
        default: act = 32'(init_busy_b);
      endcase
      check_val(c.name, act, c.value);
    end
  end

  task automatic expect_a(input int p);
    int          n;
    logic [31:0] d;
    logic        pd;
    n = int'(rd_num[p*AW +: AW]);
    if (m_left > 0) begin
      d = '0; pd = 1'b1;
    end else if (n == 0) begin
      d = '0; pd = 1'b0;
    end else if (BYP && reg_write && int'(num_write) == n) begin
      d = data_write; pd = alloc_valid && int'(alloc_num) == n;
    end else begin
      d = m_regs[n]; pd = m_pend[n];
    end
    exp_q.push_back('{0, p, d, $sformatf("a_data%0d", p)});
    exp_q.push_back('{1, p, {31'b0, pd}, $sformatf("a_pend%0d", p)});
  endtask

  task automatic expect_b(input int p);
    int          n;
    logic [31:0] d;
    logic        pd;
    n = int'(rd_num_b[p*AW_B +: AW_B]);
    if (mb_left > 0) begin
      d = '0; pd = 1'b1;
    end else if (n == 0) begin
      d = '0; pd = 1'b0;
    end else begin
      d = 32'(mb_regs[n]); pd = mb_pend[n];
    end
    exp_q.push_back('{3, p, d, $sformatf("b_data%0d", p)});
    exp_q.push_back('{4, p, {31'b0, pd}, $sformatf("b_pend%0d", p)});
  endtask

  task automatic model_edge();
    if (reset) begin
      foreach (m_regs[i]) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
      m_left = NR - 1;
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      if (reg_write && num_write != 0) begin
        m_regs[num_write] = data_write;
        m_pend[num_write] = 1'b0;
      end
      if (alloc_valid && alloc_num != 0) m_pend[alloc_num] = 1'b1;
    end
    if (reset_b) begin
      foreach (mb_regs[i]) begin mb_regs[i] = '0; mb_pend[i] = 1'b0; end
      mb_left = NR_B - 1;
    end else if (mb_left > 0) begin
      mb_left--;
    end else begin
      if (reg_write_b && num_write_b != 0) begin
        mb_regs[num_write_b] = data_write_b;
        mb_pend[num_write_b] = 1'b0;
      end
      if (alloc_valid_b && alloc_num_b != 0) mb_pend[alloc_num_b] = 1'b1;
    end
  endtask

  // Expectations are queued for the monitor, then the edge advances the model.
  task automatic cycle(input bit chk_a, input bit chk_b);
    if (chk_a) begin
      for (int p = 0; p < NRD; p++) expect_a(p);
      exp_q.push_back('{2, 0, {31'b0, (m_left > 0)}, "a_busy"});
    end
    if (chk_b) begin
      for (int p = 0; p < NRD_B; p++) expect_b(p);
      exp_q.push_back('{5, 0, {31'b0, (mb_left > 0)}, "b_busy"});
    end
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle_a();
    reg_write = 1'b0; num_write = '0; data_write = '0; alloc_valid = 1'b0; alloc_num = '0;
  endtask

  task automatic idle_b();
    reg_write_b = 1'b0; num_write_b = '0; data_write_b = '0; alloc_valid_b = 1'b0; alloc_num_b = '0;
  endtask

  task automatic set_rd_a(input int p, input int n);
    rd_num[p*AW +: AW] = AW'(n);
  endtask

  task automatic set_rd_b(input int p, input int n);
    rd_num_b[p*AW_B +: AW_B] = AW_B'(n);
  endtask

  task automatic rand_a(input int wr_pct, input int al_pct);
    rd_num      = (NRD*AW)'($urandom);
    reg_write   = ($urandom_range(0, 99) < wr_pct);
    num_write   = AW'($urandom);
    data_write  = $urandom;
    alloc_valid = ($urandom_range(0, 99) < al_pct);
    alloc_num   = AW'($urandom);
  endtask

  task automatic run_init_a(input string nm);
    int n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      rand_a(60, 40);
      cycle(1'b1, 1'b0);
      n++;
    end
    idle_a();
    check_val(nm, n, NR - 1);
    check_val({nm, "_state"}, 32'(state_dbg == GPR_RUN), 32'd1);
  endtask

  task automatic run_init_b();
    int n = 0;
    while (init_busy_b === 1'b1 && n < 100) begin
      rd_num_b = (NRD_B*AW_B)'($urandom);
      reg_write_b = 1'b1; num_write_b = AW_B'($urandom); data_write_b = DW_B'($urandom);
      cycle(1'b0, 1'b1);
      n++;
    end
    idle_b();
    check_val("b_init_len", n, NR_B - 1);
  endtask

  task automatic sweep_zero_a();
    for (int i = 1; i < NR; i++) begin
      set_rd_a(0, i);
      set_rd_a(1, NR - i);
      cycle(1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [DW_B-1:0] bv [3];
    idle_a(); idle_b();
    rd_num = '0; rd_num_b = '0;
    reset = 1'b1; reset_b = 1'b1;
    cycle(1'b0, 1'b0);
    reset = 1'b0; reset_b = 1'b0;
    run_init_a("init_len_first");

    // Garbage, then reset from RUN must wipe it.
    repeat (20) begin rand_a(80, 30); cycle(1'b1, 1'b0); end
    idle_a();
    reset = 1'b1; cycle(1'b1, 1'b0); reset = 1'b0;
    run_init_a("init_len_after_run");
    sweep_zero_a();

    set_rd_a(0, 5); set_rd_a(1, 0);
    reg_write = 1'b1; num_write = 5; data_write = 32'hDEADBEEF;
    cycle(1'b1, 1'b0); idle_a();
    check_val("wr5_next", rd_data[31:0], 32'hDEADBEEF);
    set_rd_a(0, 0);
    reg_write = 1'b1; num_write = 0; data_write = 32'h1234;
    cycle(1'b1, 1'b0); idle_a();
    check_val("wr0_zero", rd_data[31:0], 32'h0);

    set_rd_a(0, 7);
    alloc_valid = 1'b1; alloc_num = 7;
    cycle(1'b1, 1'b0); idle_a();
    check_val("alloc7_pend", 32'(rd_pending[0]), 32'd1);
    reg_write = 1'b1; num_write = 7; data_write = 32'h55;
    cycle(1'b1, 1'b0); idle_a();
    check_val("wr7_pend", 32'(rd_pending[0]), 32'd0);
    check_val("wr7_data", rd_data[31:0], 32'h55);
    reg_write = 1'b1; num_write = 7; data_write = 32'h66; alloc_valid = 1'b1; alloc_num = 7;
    cycle(1'b1, 1'b0); idle_a();
    check_val("wr_alloc7_pend", 32'(rd_pending[0]), 32'd1);
    check_val("wr_alloc7_data", rd_data[31:0], 32'h66);

    set_rd_a(0, 3); set_rd_a(1, 3);
    reg_write = 1'b1; num_write = 3; data_write = 32'hA5A5A5A5;
    #1;
    check_val("byp_p0_data", rd_data[31:0], BYP ? 32'hA5A5A5A5 : 32'h0);
    check_val("byp_p1_data", rd_data[63:32], BYP ? 32'hA5A5A5A5 : 32'h0);
    check_val("byp_pend", 32'(rd_pending), 32'd0);
    cycle(1'b1, 1'b0); idle_a();
    check_val("wr3_p1_next", rd_data[63:32], 32'hA5A5A5A5);

    repeat (300) begin rand_a(50, 25); cycle(1'b1, 1'b0); end
    idle_a();

    // Reset in the middle of the clear sequence restarts it; INIT writes are dropped.
    reset = 1'b1; cycle(1'b1, 1'b0); reset = 1'b0;
    repeat (10) begin rand_a(90, 50); cycle(1'b1, 1'b0); end
    idle_a();
    reset = 1'b1; cycle(1'b1, 1'b0); reset = 1'b0;
    run_init_a("init_len_mid_reset");
    sweep_zero_a();

    // Narrow instance: 16-bit data, 8 registers, 3 read ports.
    reset_b = 1'b1; cycle(1'b0, 1'b1); reset_b = 1'b0;
    run_init_b();
    bv[0] = DW_B'($urandom); bv[1] = DW_B'($urandom); bv[2] = DW_B'($urandom);
    for (int k = 0; k < 3; k++) begin
      reg_write_b = 1'b1;
      num_write_b = (k == 0) ? 3'd1 : (k == 1) ? 3'd2 : 3'd7;
      data_write_b = bv[k];
      cycle(1'b0, 1'b0);
    end
    idle_b();
    set_rd_b(0, 1); set_rd_b(1, 2); set_rd_b(2, 7);
    #1;
    check_val("b_r1", 32'(rd_data_b[15:0]), 32'(bv[0]));
    check_val("b_r2", 32'(rd_data_b[31:16]), 32'(bv[1]));
    check_val("b_r7", 32'(rd_data_b[47:32]), 32'(bv[2]));
    cycle(1'b0, 1'b1);
    repeat (20) begin rd_num_b = (NRD_B*AW_B)'($urandom); cycle(1'b0, 1'b1); end

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
